// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the execute-stage branch resolver: opcodes, FSM states
// and the sequential PC step.
package r200_branch_pkg;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_JAL  = 3'b010;
  localparam logic [2:0] OP_NOP  = 3'b011;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/branch_resolve_cond.sv
// Maps a branch opcode plus the comparator flags (gts/gtu/eq) onto the
// taken condition. Purely combinational.
module branch_cond
  import r200_branch_pkg::*;
(
  input  logic [2:0] op,
  input  logic       gts,
  input  logic       gtu,
  input  logic       eq,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (op)
      OP_BEQ:  cond = eq;
      OP_BNE:  cond = !eq;
      OP_JAL:  cond = 1'b1;
      OP_NOP:  cond = 1'b0;
      OP_BLT:  cond = !gts && !eq;
      OP_BGE:  cond = gts || eq;
      OP_BLTU: cond = !gtu && !eq;
      OP_BGEU: cond = gtu || eq;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: registers taken/next_pc behind a one-deep
// valid/ready stage, pulses redirect on taken branches, then drops wrong-path ops.
module branch_resolve
  import r200_branch_pkg::*;
#(
  parameter int unsigned FLUSH_CNT = 2,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            gts,
  input  logic            gtu,
  input  logic            eq,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic            squashing
);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic            redirect_q, redirect_d;
  logic            cond;
  logic            xfer;

  branch_cond u_cond (
    .op   (op),
    .gts  (gts),
    .gtu  (gtu),
    .eq   (eq),
    .cond (cond)
  );

  assign in_ready  = (state_q == ST_SQUASH) ? 1'b1 : (!out_valid_q || out_ready);
  assign xfer      = in_valid && in_ready;
  assign squashing = (state_q == ST_SQUASH);
  assign out_valid = out_valid_q;
  assign taken     = taken_q;
  assign next_pc   = next_pc_q;
  assign redirect  = redirect_q;

  // The pending result drains in either state; only RUN may refill it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    taken_d     = taken_q;
    next_pc_d   = next_pc_q;
    redirect_d  = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (xfer) begin
          out_valid_d = 1'b1;
          taken_d     = cond;
          next_pc_d   = cond ? (pc + imm) : (pc + XLEN'(PC_INC));
          redirect_d  = cond;
          if (cond && (FLUSH_CNT != 0)) begin
            state_d = ST_SQUASH;
            cnt_d   = 4'(FLUSH_CNT);
          end
        end
      end
      ST_SQUASH: begin
        if (xfer) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      next_pc_q   <= '0;
      redirect_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      next_pc_q   <= next_pc_d;
      redirect_q  <= redirect_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed ops push expected results,
// a negedge monitor pops and compares whenever the DUT hands a result over.
module tb_branch_resolve;
  import r200_branch_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        gts;
  logic        gtu;
  logic        eq;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] next_pc;
  logic        redirect;
  logic        squashing;

  typedef struct {
    logic        taken;
    logic [31:0] npc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  logic expect_fresh;
  logic prev_valid;
  logic prev_hs;

  branch_resolve #(.FLUSH_CNT(2), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .pc        (pc),
    .imm       (imm),
    .gts       (gts),
    .gtu       (gtu),
    .eq        (eq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .next_pc   (next_pc),
    .redirect  (redirect),
    .squashing (squashing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one op starting just after a posedge and returns on the transfer edge.
  task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] p, input logic [31:0] i,
                                input logic g_s, input logic g_u, input logic e,
                                input logic drop, input logic exp_taken, input logic [31:0] exp_npc);
    exp_t e_item;
    bit   done;
    #1;
    in_valid = 1'b1; op = o; pc = p; imm = i; gts = g_s; gtu = g_u; eq = e;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        check_output("squashing_at_xfer", {31'd0, squashing}, {31'd0, drop});
        done = 1;
      end
      @(posedge clk);
    end
    if (!done) begin
      check_output("in_ready_timeout", 32'd0, 32'd1);
    end else if (!drop) begin
      e_item.taken = exp_taken;
      e_item.npc   = exp_npc;
      sb.push_back(e_item);
      expect_fresh = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    #1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: a result is fresh on its first visible cycle, which is when redirect may pulse.
  always @(negedge clk) begin
    logic fresh;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      fresh = out_valid && !(prev_valid && !prev_hs);
      if (expect_fresh) begin
        check_output("latency_one_cycle", {31'd0, out_valid && fresh}, 32'd1);
        expect_fresh = 1'b0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check_output("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          check_output("redirect", {31'd0, redirect}, {31'd0, fresh && sb[0].taken});
          if (out_ready) begin
            check_output("taken", {31'd0, taken}, {31'd0, sb[0].taken});
            check_output("next_pc", next_pc, sb[0].npc);
            void'(sb.pop_front());
          end
        end
      end else begin
        check_output("redirect_idle", {31'd0, redirect}, 32'd0);
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
    end
  end

  initial begin
    checks = 0; failures = 0; expect_fresh = 1'b0;
    prev_valid = 1'b0; prev_hs = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_NOP; pc = '0; imm = '0; gts = 0; gtu = 0; eq = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_taken", {31'd0, taken}, 32'd0);
    check_output("rst_next_pc", next_pc, 32'd0);
    check_output("rst_redirect", {31'd0, redirect}, 32'd0);
    check_output("rst_squashing", {31'd0, squashing}, 32'd0);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // BLT -23 vs 23 taken, two wrong-path drops, then BLTU same flags not taken
    apply_stimulus(OP_BLT,  32'h100, 32'h20, 0, 1, 0, 0, 1, 32'h120);
    apply_stimulus(OP_NOP,  32'h104, 32'h0,  0, 0, 0, 1, 0, 32'h0);
    apply_stimulus(OP_NOP,  32'h108, 32'h0,  0, 0, 0, 1, 0, 32'h0);
    apply_stimulus(OP_BLTU, 32'h100, 32'h20, 0, 1, 0, 0, 0, 32'h104);
    idle(2);

    apply_stimulus(OP_BEQ,  32'h200, 32'h40, 0, 0, 1, 0, 1, 32'h240);
    apply_stimulus(OP_NOP,  32'h0,   32'h0,  0, 0, 0, 1, 0, 32'h0);
    apply_stimulus(OP_NOP,  32'h0,   32'h0,  0, 0, 0, 1, 0, 32'h0);
    apply_stimulus(OP_BNE,  32'h300, 32'h8,  1, 1, 0, 0, 1, 32'h308);
    apply_stimulus(OP_NOP,  32'h0,   32'h0,  0, 0, 0, 1, 0, 32'h0);
    apply_stimulus(OP_NOP,  32'h0,   32'h0,  0, 0, 0, 1, 0, 32'h0);
    apply_stimulus(OP_BGEU, 32'h400, 32'hFFFF_FFF8, 1, 1, 0, 0, 1, 32'h3F8);
    apply_stimulus(OP_NOP,  32'h0,   32'h0,  0, 0, 0, 1, 0, 32'h0);
    apply_stimulus(OP_NOP,  32'h0,   32'h0,  0, 0, 0, 1, 0, 32'h0);
    apply_stimulus(OP_BGE,  32'h500, 32'h80, 0, 1, 0, 0, 0, 32'h504);
    apply_stimulus(OP_BLT,  32'h510, 32'h80, 1, 0, 0, 0, 0, 32'h514);
    idle(2);

    // JAL then three back-to-back ops: two dropped, third forwarded
    apply_stimulus(OP_JAL,  32'h1000, 32'h100, 0, 0, 0, 0, 1, 32'h1100);
    apply_stimulus(OP_BEQ,  32'h1004, 32'h0,   0, 0, 1, 1, 0, 32'h0);
    apply_stimulus(OP_BEQ,  32'h1008, 32'h0,   0, 0, 1, 1, 0, 32'h0);
    apply_stimulus(OP_NOP,  32'h2000, 32'h0,   0, 0, 0, 0, 0, 32'h2004);
    idle(2);

    // Backpressure: five stalled cycles, then drain and fill together
    #1 out_ready = 1'b0;
    @(posedge clk);
    apply_stimulus(OP_NOP,  32'h600, 32'h0, 0, 0, 0, 0, 0, 32'h604);
    #1;
    in_valid = 1'b1; op = OP_BLTU; pc = 32'h700; imm = 32'h0; gts = 0; gtu = 1; eq = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("stall_next_pc", next_pc, 32'h604);
      check_output("stall_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    apply_stimulus(OP_BLTU, 32'h700, 32'h0, 0, 1, 0, 0, 0, 32'h704);
    apply_stimulus(OP_NOP,  32'h800, 32'h0, 0, 0, 0, 0, 0, 32'h804);
    idle(2);

    // PC wrap-around in both directions
    apply_stimulus(OP_NOP,  32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    apply_stimulus(OP_BEQ,  32'h10, 32'hFFFF_FFF0, 0, 0, 1, 0, 1, 32'h0);
    apply_stimulus(OP_NOP,  32'h0,  32'h0, 0, 0, 0, 1, 0, 32'h0);
    apply_stimulus(OP_NOP,  32'h0,  32'h0, 0, 0, 0, 1, 0, 32'h0);
    idle(2);

    // Reset with one drop still owed; the next op must be forwarded
    apply_stimulus(OP_JAL,  32'h40, 32'h10, 0, 0, 0, 0, 1, 32'h50);
    apply_stimulus(OP_NOP,  32'h44, 32'h0,  0, 0, 0, 1, 0, 32'h0);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_output("post_rst_squashing", {31'd0, squashing}, 32'd0);
    check_output("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    apply_stimulus(OP_BNE,  32'h60, 32'h20, 0, 0, 1, 0, 0, 32'h64);
    idle(4);

    check_output("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 0 expected 1");
    $fatal(1, "[TB] timeout");
  end

endmodule
